// File: rtl/mem_rd_stream.sv
// ============================================================================
//  Module   : mem_rd_stream
//  Purpose  : Sequential read master for a 1-cycle-latency memory port that
//             re-emits returned words as a valid/ready stream via a small FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rd_stream #(
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_MAX_ADDRESS = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int LOG_FIFO_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LOG_MAX_ADDRESS-1:0] base_addr,
    input  logic [LOG_MAX_ADDRESS:0]   num_words,
    output logic                       busy,
    output logic                       done,
    output logic [LOG_MAX_ADDRESS-1:0] mem_addr_read,
    output logic                       mem_read,
    input  logic [DATA_WIDTH-1:0]      mem_data_read,
    input  logic                       mem_valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       valid_out,
    input  logic                       ready_in
);

    localparam int AW = LOG_MAX_ADDRESS;
    localparam int RW = LOG_MAX_ADDRESS + 1;
    localparam int PW = LOG_FIFO_DEPTH;
    localparam int CW = LOG_FIFO_DEPTH + 1;
    localparam int SW = LOG_FIFO_DEPTH + 2;

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [RW-1:0] REM_ONE  = RW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] CREDIT   = SW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic            mem_read_q, mem_read_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_last;
    logic [SW-1:0]   w_credit;

    // Both the request on the bus and the word returning this cycle are still
    // outside the FIFO, so both must be reserved before issuing another read.
    always_comb begin
        w_valid  = (count_q != '0);
        w_push   = mem_valid_out && (state_q == RUN);
        w_pop    = w_valid && ready_in;
        w_credit = SW'(count_q) + SW'(mem_read_q) + SW'(w_push);
        w_issue  = (state_q == RUN) && (rem_q != '0) && (w_credit < CREDIT);
        w_last   = (rem_q == '0) && !mem_read_q && !w_push
                   && (count_q == CNT_ONE) && w_pop;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        mem_read_d = 1'b0;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d    = RUN;
                        mem_read_d = 1'b1;
                        mem_addr_d = base_addr;
                        addr_d     = base_addr + ADDR_ONE;
                        rem_d      = num_words - REM_ONE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RUN: begin
                if (w_issue) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_ONE;
                    rem_d      = rem_q - REM_ONE;
                end
                if (w_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= mem_data_read;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && (count_q == CNT_FULL)));

    // Head is masked while empty so the stream reads zero after reset.
    assign data_out      = w_valid ? fifo_mem[rd_ptr_q] : '0;
    assign valid_out     = w_valid;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == FINISH);
    assign mem_read      = mem_read_q;
    assign mem_addr_read = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rd_stream.sv
// ============================================================================
//  Module   : tb_mem_rd_stream
//  Purpose  : Scoreboard bench for mem_rd_stream with a mem[i]=i memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rd_stream;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int LD    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr_read;
    logic          mem_read;
    logic [DW-1:0] mem_data_read = '0;
    logic          mem_valid_out = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    int            occ = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;

    mem_rd_stream #(
        .DATA_WIDTH     (DW),
        .LOG_MAX_ADDRESS(AW),
        .FIFO_DEPTH     (DEPTH),
        .LOG_FIFO_DEPTH (LD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .mem_addr_read(mem_addr_read),
        .mem_read     (mem_read),
        .mem_data_read(mem_data_read),
        .mem_valid_out(mem_valid_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in)
    );

    always #5 clk = ~clk;

    // Memory preloaded with mem[i] = i (low byte), one-cycle read latency.
    always @(posedge clk) begin
        mem_valid_out <= mem_read;
        mem_data_read <= mem_addr_read[DW-1:0];
    end

    // Waits for the next falling edge and scores reads, pops and occupancy.
    task automatic watch();
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        @(negedge clk);
        if (!rst) begin
            occ    = 0;
            hold_q = 1'b0;
        end else begin
            if (mem_read) begin
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL rd_addr: got read of %h, required no read", mem_addr_read);
                end else begin
                    ea = exp_addr.pop_front();
                    if (mem_addr_read !== ea) begin
                        bad++;
                        $display("FAIL rd_addr: got %h, required %h", mem_addr_read, ea);
                    end
                end
            end
            if (valid_out && ready_in) begin
                total++;
                if (exp_data.size() == 0) begin
                    bad++;
                    $display("FAIL pop_data: got word %h, required no word", data_out);
                end else begin
                    ed = exp_data.pop_front();
                    if (data_out !== ed) begin
                        bad++;
                        $display("FAIL pop_data: got %h, required %h", data_out, ed);
                    end
                end
            end
            if (hold_q && valid_out) begin
                total++;
                if (data_out !== hold_data) begin
                    bad++;
                    $display("FAIL hold_stable: got %h, required %h", data_out, hold_data);
                end
            end
            hold_q    = valid_out && !ready_in;
            hold_data = data_out;
            if (mem_valid_out && busy) occ++;
            if (valid_out && ready_in) occ--;
            if (mem_valid_out && busy) begin
                total++;
                if (occ > DEPTH) begin
                    bad++;
                    $display("FAIL fifo_occ: got %0d, required <= %0d", occ, DEPTH);
                end
            end
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low cycles 3..12 then random;
    // 3: ready high plus stray starts at cycles 2 and 4.
    task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                            output int done_k, output int first_rd, output int first_pop,
                            output int last_pop, output int npop, output int nread,
                            output int ndone, output int busy_bad, output int rd_at_12,
                            output logic v_at_12);
        logic exp_busy;
        done_k = -1; first_rd = -1; first_pop = -1; last_pop = -1;
        npop = 0; nread = 0; ndone = 0; busy_bad = 0; rd_at_12 = -1; v_at_12 = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(b + AW'(i));
            exp_data.push_back(DW'(b + AW'(i)));
        end
        @(posedge clk); #1;
        base_addr = b;
        num_words = (AW+1)'(n);
        start     = 1'b1;
        ready_in  = (mode == 0 || mode == 3);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start = (mode == 3) && (k == 2 || k == 4);
            if (start) begin
                base_addr = 16'd500;
                num_words = 17'd9;
            end
            case (mode)
                1:       ready_in = 1'($urandom_range(0, 1));
                2:       ready_in = (k >= 3 && k <= 12) ? 1'b0 : 1'($urandom_range(0, 1));
                default: ready_in = 1'b1;
            endcase
            watch();
            if (mem_read) begin
                nread++;
                if (first_rd < 0) first_rd = k;
            end
            if (valid_out && ready_in) begin
                npop++;
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            if (k == 12) begin
                rd_at_12 = nread;
                v_at_12  = valid_out;
            end
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            exp_busy = (done_k < 0) && (n > 0);
            if (busy !== exp_busy) busy_bad++;
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        start    = 1'b0;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", valid_out); end
        total++; if (mem_addr_read !== '0) begin bad++; $display("FAIL rst_addr: got %h required 0", mem_addr_read); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data: got %h required 0", data_out); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        logic v12;
        run_xfer(16'd10, 5, 0, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (fr !== 1) begin bad++; $display("FAIL basic_first_read: got %0d required 1", fr); end
        total++; if (fp !== 3) begin bad++; $display("FAIL basic_first_valid: got %0d required 3", fp); end
        total++; if (lp !== 7 || np !== 5) begin bad++; $display("FAIL basic_consecutive: got last=%0d n=%0d required last=7 n=5", lp, np); end
        total++; if (dk !== 8) begin bad++; $display("FAIL basic_done_cycle: got %0d required 8", dk); end
        total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d required 1", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy: got %0d bad cycles required 0", bb); end
        total++; if (exp_data.size() !== 0) begin bad++; $display("FAIL basic_left: got %0d words required 0", exp_data.size()); end
    endtask

    task automatic test_zero();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        logic v12;
        run_xfer(16'h1234, 0, 0, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (nr !== 0) begin bad++; $display("FAIL zero_reads: got %0d required 0", nr); end
        total++; if (np !== 0) begin bad++; $display("FAIL zero_pops: got %0d required 0", np); end
        total++; if (dk !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d required 1", dk); end
        total++; if (nd !== 1) begin bad++; $display("FAIL zero_done_pulses: got %0d required 1", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL zero_busy: got %0d bad cycles required 0", bb); end
    endtask

    task automatic test_wrap();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        logic v12;
        run_xfer(16'hFFFE, 4, 0, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (np !== 4) begin bad++; $display("FAIL wrap_pops: got %0d required 4", np); end
        total++; if (dk !== 7) begin bad++; $display("FAIL wrap_done_cycle: got %0d required 7", dk); end
        total++; if (exp_addr.size() !== 0) begin bad++; $display("FAIL wrap_reads_left: got %0d required 0", exp_addr.size()); end
    endtask

    task automatic test_backpressure();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        logic v12;
        run_xfer(16'd0, 16, 2, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (r12 !== DEPTH) begin bad++; $display("FAIL bp_stall_reads: got %0d required %0d", r12, DEPTH); end
        total++; if (v12 !== 1'b1) begin bad++; $display("FAIL bp_stall_valid: got %b required 1", v12); end
        total++; if (np !== 16) begin bad++; $display("FAIL bp_pops: got %0d required 16", np); end
        total++; if (nd !== 1) begin bad++; $display("FAIL bp_done_pulses: got %0d required 1", nd); end
        total++; if (exp_data.size() !== 0) begin bad++; $display("FAIL bp_left: got %0d required 0", exp_data.size()); end
        run_xfer(16'h0020, 12, 1, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (np !== 12) begin bad++; $display("FAIL rand_pops: got %0d required 12", np); end
        total++; if (bb !== 0) begin bad++; $display("FAIL rand_busy: got %0d bad cycles required 0", bb); end
    endtask

    task automatic test_reset_mid();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        int pops, dones;
        logic v12;
        pops = 0; dones = 0;
        for (int i = 0; i < 16; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(DW'(i));
        end
        @(posedge clk); #1;
        base_addr = '0; num_words = 17'd16; start = 1'b1; ready_in = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            watch();
            if (valid_out && ready_in) pops++;
            if (pops >= 3) break;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        watch();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || mem_read !== 1'b0 || valid_out !== 1'b0)
            begin bad++; $display("FAIL mid_rst_flags: got busy=%b done=%b rd=%b vld=%b required all 0", busy, done, mem_read, valid_out); end
        total++; if (mem_addr_read !== '0 || data_out !== '0)
            begin bad++; $display("FAIL mid_rst_buses: got addr=%h data=%h required 0", mem_addr_read, data_out); end
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            watch();
            if (done) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses required 0", dones); end
        ready_in = 1'b0;
        run_xfer(16'd40, 2, 0, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (np !== 2) begin bad++; $display("FAIL mid_new_pops: got %0d required 2", np); end
        total++; if (dk !== 5) begin bad++; $display("FAIL mid_new_done: got %0d required 5", dk); end
    endtask

    task automatic test_start_busy();
        int dk, fr, fp, lp, np, nr, nd, bb, r12;
        logic v12;
        run_xfer(16'd100, 6, 3, dk, fr, fp, lp, np, nr, nd, bb, r12, v12);
        total++; if (nr !== 6) begin bad++; $display("FAIL sb_reads: got %0d required 6", nr); end
        total++; if (np !== 6) begin bad++; $display("FAIL sb_pops: got %0d required 6", np); end
        total++; if (dk !== 9 || nd !== 1) begin bad++; $display("FAIL sb_done: got cycle=%0d n=%0d required cycle=9 n=1", dk, nd); end
        total++; if (exp_data.size() !== 0) begin bad++; $display("FAIL sb_left: got %0d required 0", exp_data.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
